// File: rtl/vdic_serial_cmd_rx.sv
// Serial command receiver: deserialises 10-bit din words, gathers operand bytes
// and hands one decoded command per control word to the ALU over valid/ready.
module vdic_serial_cmd_rx #(
   parameter int unsigned NUM_ARGS = 2,
   parameter logic [7:0]  OP_ADD   = 8'h10,
   parameter logic [7:0]  OP_AND   = 8'h01
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    enable_n,
   input  logic                    din,
   output logic                    cmd_valid,
   input  logic                    cmd_ready,
   output logic [7:0]              cmd_op,
   output logic [8*NUM_ARGS-1:0]   cmd_args,
   output logic [7:0]              cmd_status,
   output logic                    rx_abort,
   output logic                    rx_overrun
);

   localparam int unsigned ARGS_W = 8 * NUM_ARGS;
   localparam int unsigned CNT_W  = $clog2(NUM_ARGS + 1);
   localparam int unsigned BCNT_W = 4;
   localparam logic [CNT_W-1:0]  ARG_MAX  = CNT_W'(NUM_ARGS);
   localparam logic [BCNT_W-1:0] LAST_BIT = BCNT_W'(9);

   typedef enum logic [0:0] {IDLE, RECV} state_t;

   state_t              state_q, state_d;
   logic [BCNT_W-1:0]   bit_cnt_q, bit_cnt_d;
   logic [8:0]          shift_q, shift_d;
   logic [CNT_W-1:0]    arg_cnt_q, arg_cnt_d;
   logic [ARGS_W-1:0]   args_q, args_d;
   logic                par_err_q, par_err_d;
   logic                cnt_err_q, cnt_err_d;
   logic                cmd_valid_q, cmd_valid_d;
   logic [7:0]          cmd_op_q, cmd_op_d;
   logic [ARGS_W-1:0]   cmd_args_q, cmd_args_d;
   logic [7:0]          cmd_status_q, cmd_status_d;
   logic                rx_abort_q, rx_abort_d;
   logic                rx_overrun_q, rx_overrun_d;

   logic [9:0]          word_c;
   logic                word_done_c, ctrl_done_c, par_bad_c, abort_c, op_bad_c;

   // Completed word is the nine buffered bits plus the parity bit on din now.
   assign word_c      = {shift_q, din};
   assign word_done_c = (state_q == RECV) && !enable_n && (bit_cnt_q == LAST_BIT);
   assign ctrl_done_c = word_done_c && word_c[9];
   assign par_bad_c   = word_c[0] ^ (^word_c[9:1]);
   assign abort_c     = (state_q == RECV) && enable_n && (bit_cnt_q != '0);
   assign op_bad_c    = !((word_c[8:1] == OP_ADD) || (word_c[8:1] == OP_AND));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         bit_cnt_q    <= '0;
         shift_q      <= '0;
         arg_cnt_q    <= '0;
         args_q       <= '0;
         par_err_q    <= 1'b0;
         cnt_err_q    <= 1'b0;
         cmd_valid_q  <= 1'b0;
         cmd_op_q     <= '0;
         cmd_args_q   <= '0;
         cmd_status_q <= '0;
         rx_abort_q   <= 1'b0;
         rx_overrun_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         bit_cnt_q    <= bit_cnt_d;
         shift_q      <= shift_d;
         arg_cnt_q    <= arg_cnt_d;
         args_q       <= args_d;
         par_err_q    <= par_err_d;
         cnt_err_q    <= cnt_err_d;
         cmd_valid_q  <= cmd_valid_d;
         cmd_op_q     <= cmd_op_d;
         cmd_args_q   <= cmd_args_d;
         cmd_status_q <= cmd_status_d;
         rx_abort_q   <= rx_abort_d;
         rx_overrun_q <= rx_overrun_d;
      end
   end

   // Receive path: bit framing, operand collection and sticky error tracking.
   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      arg_cnt_d = arg_cnt_q;
      args_d    = args_q;
      par_err_d = par_err_q;
      cnt_err_d = cnt_err_q;
      case (state_q)
         IDLE: begin
            if (!enable_n) begin
               state_d   = RECV;
               shift_d   = {shift_q[7:0], din};
               bit_cnt_d = BCNT_W'(1);
            end
         end
         RECV: begin
            if (!enable_n) begin
               shift_d   = {shift_q[7:0], din};
               bit_cnt_d = (bit_cnt_q == LAST_BIT) ? '0 : bit_cnt_q + BCNT_W'(1);
               if (word_done_c && !word_c[9]) begin
                  par_err_d = par_err_q | par_bad_c;
                  if (arg_cnt_q < ARG_MAX) begin
                     for (int unsigned i = 0; i < NUM_ARGS; i++) begin
                        if (CNT_W'(i) == arg_cnt_q) args_d[i*8 +: 8] = word_c[8:1];
                     end
                     arg_cnt_d = arg_cnt_q + CNT_W'(1);
                  end else begin
                     cnt_err_d = 1'b1;
                  end
               end else if (ctrl_done_c) begin
                  arg_cnt_d = '0;
                  args_d    = '0;
                  par_err_d = 1'b0;
                  cnt_err_d = 1'b0;
               end
            end else if (abort_c) begin
               state_d   = IDLE;
               bit_cnt_d = '0;
               shift_d   = '0;
               arg_cnt_d = '0;
               args_d    = '0;
               par_err_d = 1'b0;
               cnt_err_d = 1'b0;
            end else begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Command output and handshake; a held, unaccepted command wins over a new one.
   always_comb begin
      cmd_valid_d  = cmd_valid_q;
      cmd_op_d     = cmd_op_q;
      cmd_args_d   = cmd_args_q;
      cmd_status_d = cmd_status_q;
      rx_abort_d   = abort_c;
      rx_overrun_d = 1'b0;
      if (cmd_valid_q && cmd_ready) cmd_valid_d = 1'b0;
      if (ctrl_done_c) begin
         if (cmd_valid_q && !cmd_ready) begin
            rx_overrun_d = 1'b1;
         end else begin
            cmd_valid_d  = 1'b1;
            cmd_op_d     = word_c[8:1];
            cmd_args_d   = args_q;
            cmd_status_d = {op_bad_c, par_err_q | par_bad_c,
                            cnt_err_q | (arg_cnt_q != ARG_MAX), 5'b0};
         end
      end
   end

   assign cmd_valid  = cmd_valid_q;
   assign cmd_op     = cmd_op_q;
   assign cmd_args   = cmd_args_q;
   assign cmd_status = cmd_status_q;
   assign rx_abort   = rx_abort_q;
   assign rx_overrun = rx_overrun_q;

endmodule

// File: tb/tb_vdic_serial_cmd_rx.sv
// Bench for vdic_serial_cmd_rx: directed frames, expected commands queued and
// checked by an independent monitor at each accepted transfer.
module tb_vdic_serial_cmd_rx;

   typedef struct packed {
      logic [7:0]  op;
      logic [15:0] args;
      logic [7:0]  status;
   } cmd_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        enable_n;
   logic        din;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [7:0]  cmd_op;
   logic [15:0] cmd_args;
   logic [7:0]  cmd_status;
   logic        rx_abort;
   logic        rx_overrun;

   int   checks = 0;
   int   errors = 0;
   int   abort_cnt = 0;
   int   overrun_cnt = 0;
   logic abort_prev = 1'b0;
   cmd_t exp_q[$];

   vdic_serial_cmd_rx #(.NUM_ARGS(2), .OP_ADD(8'h10), .OP_AND(8'h01)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .enable_n  (enable_n),
      .din       (din),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_args  (cmd_args),
      .cmd_status(cmd_status),
      .rx_abort  (rx_abort),
      .rx_overrun(rx_overrun)
   );

   always #5 clk = ~clk;

   // Monitor: every accepted transfer must match the oldest expected command.
   always @(negedge clk) begin
      cmd_t got;
      cmd_t exp;
      if (cmd_valid && cmd_ready) begin
         got = {cmd_op, cmd_args, cmd_status};
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL cmd_unexpected: got op=%h args=%h status=%h, none expected",
                     cmd_op, cmd_args, cmd_status);
         end else begin
            exp = exp_q.pop_front();
            if (got !== exp) begin
               errors++;
               $display("FAIL cmd: got op=%h args=%h status=%h, expected op=%h args=%h status=%h",
                        got.op, got.args, got.status, exp.op, exp.args, exp.status);
            end
         end
      end
      if (rx_abort) begin
         abort_cnt++;
         checks++;
         if (abort_prev) begin
            errors++;
            $display("FAIL abort_width: rx_abort high on consecutive cycles, expected 1-cycle pulse");
         end
      end
      if (rx_overrun) overrun_cnt++;
      abort_prev = rx_abort;
   end

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, got, exp);
      end
   endtask

   function automatic logic [9:0] mk(input logic ctrl, input logic [7:0] b, input logic flip);
      return {ctrl, b, (^{ctrl, b}) ^ flip};
   endfunction

   task automatic send_bits(input logic [9:0] w, input int n);
      for (int i = 9; i > 9 - n; i--) begin
         din      = w[i];
         enable_n = 1'b0;
         @(posedge clk); #1;
      end
   endtask

   task automatic send_word(input logic ctrl, input logic [7:0] b, input logic flip = 1'b0);
      send_bits(mk(ctrl, b, flip), 10);
   endtask

   task automatic idle(input int n);
      enable_n = 1'b1;
      din      = 1'b0;
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic expect_cmd(input logic [7:0] op, input logic [15:0] args, input logic [7:0] st);
      exp_q.push_back({op, args, st});
   endtask

   task automatic frame3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op);
      send_word(1'b0, a);
      send_word(1'b0, b);
      send_word(1'b1, op);
   endtask

   initial begin
      int ov0;
      rst_n = 1'b0; enable_n = 1'b1; din = 1'b0; cmd_ready = 1'b1;
      #12;
      check("reset_valid",   32'(cmd_valid), 32'h0);
      check("reset_op",      32'(cmd_op), 32'h0);
      check("reset_args",    32'(cmd_args), 32'h0);
      check("reset_status",  32'(cmd_status), 32'h0);
      check("reset_pulses",  32'({rx_abort, rx_overrun}), 32'h0);
      @(posedge clk); #1; rst_n = 1'b1;
      idle(2);

      // Clean add command; valid visible one cycle after the last bit
      expect_cmd(8'h10, 16'h3412, 8'h00);
      frame3(8'h12, 8'h34, 8'h10);
      check("latency_valid", 32'(cmd_valid), 32'h1);
      idle(1);
      check("valid_drop", 32'(cmd_valid), 32'h0);
      idle(1);

      // Unsupported opcode
      expect_cmd(8'h55, 16'h00FF, 8'h80);
      frame3(8'hFF, 8'h00, 8'h55);
      idle(2);

      // Bad data parity, then a clean frame must not inherit it
      expect_cmd(8'h01, 16'h01A5, 8'h40);
      send_word(1'b0, 8'hA5, 1'b1);
      send_word(1'b0, 8'h01);
      send_word(1'b1, 8'h01);
      idle(1);
      expect_cmd(8'h10, 16'h3412, 8'h00);
      frame3(8'h12, 8'h34, 8'h10);
      idle(2);

      // Too many args, then too few; back-to-back words without gaps
      expect_cmd(8'h10, 16'h0201, 8'h20);
      send_word(1'b0, 8'h01);
      send_word(1'b0, 8'h02);
      send_word(1'b0, 8'h03);
      send_word(1'b1, 8'h10);
      expect_cmd(8'h01, 16'h0007, 8'h20);
      send_word(1'b0, 8'h07);
      send_word(1'b1, 8'h01);
      idle(2);

      // Bad parity on the control word itself
      expect_cmd(8'h01, 16'h2211, 8'h40);
      send_word(1'b0, 8'h11);
      send_word(1'b0, 8'h22);
      send_word(1'b1, 8'h01, 1'b1);
      idle(2);

      // Abort mid-word discards the stored arg as well
      send_word(1'b0, 8'h99);
      send_bits(mk(1'b0, 8'h12, 1'b0), 5);
      idle(3);
      check("abort_count", 32'(abort_cnt), 32'd1);
      check("abort_no_valid", 32'(cmd_valid), 32'h0);
      expect_cmd(8'h10, 16'h3412, 8'h00);
      frame3(8'h12, 8'h34, 8'h10);
      idle(2);

      // Backpressure: second command is dropped with an overrun pulse
      cmd_ready = 1'b0;
      ov0 = overrun_cnt;
      expect_cmd(8'h10, 16'h3412, 8'h00);
      frame3(8'h12, 8'h34, 8'h10);
      idle(1);
      check("held_valid", 32'(cmd_valid), 32'h1);
      frame3(8'h0A, 8'h0B, 8'h01);
      idle(2);
      check("overrun_count", 32'(overrun_cnt - ov0), 32'd1);
      check("held_op",     32'(cmd_op), 32'h10);
      check("held_args",   32'(cmd_args), 32'h3412);
      check("held_status", 32'(cmd_status), 32'h00);
      check("held_valid2", 32'(cmd_valid), 32'h1);
      cmd_ready = 1'b1;
      @(posedge clk); #1;
      check("release_drop", 32'(cmd_valid), 32'h0);
      idle(1);

      // Reset mid-word with a held command: everything clears asynchronously
      cmd_ready = 1'b0;
      expect_cmd(8'h01, 16'h4433, 8'h00);
      frame3(8'h33, 8'h44, 8'h01);
      idle(1);
      check("pre_reset_valid", 32'(cmd_valid), 32'h1);
      send_word(1'b0, 8'h77);
      send_bits(mk(1'b0, 8'h66, 1'b0), 4);
      rst_n = 1'b0;
      #2;
      check("async_rst_valid",  32'(cmd_valid), 32'h0);
      check("async_rst_op",     32'(cmd_op), 32'h0);
      check("async_rst_args",   32'(cmd_args), 32'h0);
      check("async_rst_status", 32'(cmd_status), 32'h0);
      check("async_rst_pulses", 32'({rx_abort, rx_overrun}), 32'h0);
      exp_q.delete();
      enable_n  = 1'b1;
      cmd_ready = 1'b1;
      @(posedge clk); #1; rst_n = 1'b1;
      idle(1);
      expect_cmd(8'h10, 16'h3412, 8'h00);
      frame3(8'h12, 8'h34, 8'h10);
      idle(3);

      check("queue_drained", 32'(exp_q.size()), 32'd0);
      check("abort_total", 32'(abort_cnt), 32'd1);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
